// File: rtl/surface_ray_arbiter.sv
// surface_ray_arbiter
//   Buffers primary and reflection rays in two small FIFOs and issues one ray
//   at a time to the downstream surface unit. Reflection rays win by default,
//   but after REF_BURST consecutive reflection grants with a primary ray
//   waiting, one primary ray is forced through. Each issue is followed by one
//   dead cycle so the downstream full flag can settle.
//
// Ports
//   clk              rising-edge clock
//   resetn           asynchronous active-low reset
//   add_input        primary ray write strobe
//   input_data       primary ray payload
//   fifo_full        primary FIFO full (registered)
//   add_ref_input    reflection ray write strobe
//   ref_input_data   reflection ray payload
//   ref_fifo_full    reflection FIFO full (registered)
//   output_fifo_full downstream cannot accept
//   valid            one-cycle pulse, out carries a ray
//   out              registered granted ray, holds while valid is low

package surface_ray_pkg;
  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [7:0]  ray_id;
  } SurfaceInputData;
endpackage

module surface_ray_arbiter
  import surface_ray_pkg::*;
#(
  parameter int unsigned PRIM_DEPTH = 2,
  parameter int unsigned REF_DEPTH  = 2,
  parameter int unsigned REF_BURST  = 4
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            add_input,
  input  SurfaceInputData input_data,
  output logic            fifo_full,
  input  logic            add_ref_input,
  input  SurfaceInputData ref_input_data,
  output logic            ref_fifo_full,
  input  logic            output_fifo_full,
  output logic            valid,
  output SurfaceInputData out
);

  localparam int unsigned PW  = $clog2(PRIM_DEPTH);
  localparam int unsigned PCW = PW + 1;
  localparam int unsigned RW  = $clog2(REF_DEPTH);
  localparam int unsigned RCW = RW + 1;
  localparam int unsigned BW  = $clog2(REF_BURST + 1);

  localparam logic [PCW-1:0] P_FULL    = PCW'(PRIM_DEPTH);
  localparam logic [RCW-1:0] R_FULL    = RCW'(REF_DEPTH);
  localparam logic [BW-1:0]  BURST_MAX = BW'(REF_BURST);

  typedef enum logic {
    IDLE,
    ISSUED
  } state_t;

  state_t state;

  // Primary FIFO
  SurfaceInputData  p_mem [PRIM_DEPTH];
  logic [PW-1:0]    p_wr_ptr, p_rd_ptr;
  logic [PCW-1:0]   p_cnt, p_cnt_nxt;
  logic             p_ne, p_wr_en, p_pop;

  // Reflection FIFO
  SurfaceInputData  r_mem [REF_DEPTH];
  logic [RW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [RCW-1:0]   r_cnt, r_cnt_nxt;
  logic             r_ne, r_wr_en, r_pop;

  logic [BW-1:0]    burst_cnt;
  logic             issue, grant_ref;

  always_comb begin
    // Emptiness uses the registered count, so a same-edge write never bypasses.
    p_ne      = (p_cnt != '0);
    r_ne      = (r_cnt != '0);
    p_wr_en   = add_input && !fifo_full;
    r_wr_en   = add_ref_input && !ref_fifo_full;
    issue     = (state == IDLE) && !output_fifo_full && (p_ne || r_ne);
    grant_ref = r_ne && !(p_ne && (burst_cnt == BURST_MAX));
    p_pop     = issue && !grant_ref;
    r_pop     = issue && grant_ref;
    p_cnt_nxt = p_cnt + PCW'(p_wr_en) - PCW'(p_pop);
    r_cnt_nxt = r_cnt + RCW'(r_wr_en) - RCW'(r_pop);
  end

  // Storage arrays carry no reset; validity is tracked by the counts.
  always_ff @(posedge clk) begin
    if (p_wr_en) p_mem[p_wr_ptr] <= input_data;
    if (r_wr_en) r_mem[r_wr_ptr] <= ref_input_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      p_wr_ptr      <= '0;
      p_rd_ptr      <= '0;
      p_cnt         <= '0;
      fifo_full     <= 1'b0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_cnt         <= '0;
      ref_fifo_full <= 1'b0;
    end else begin
      if (p_wr_en) p_wr_ptr <= p_wr_ptr + PW'(1);
      if (p_pop)   p_rd_ptr <= p_rd_ptr + PW'(1);
      p_cnt     <= p_cnt_nxt;
      fifo_full <= (p_cnt_nxt == P_FULL);
      if (r_wr_en) r_wr_ptr <= r_wr_ptr + RW'(1);
      if (r_pop)   r_rd_ptr <= r_rd_ptr + RW'(1);
      r_cnt         <= r_cnt_nxt;
      ref_fifo_full <= (r_cnt_nxt == R_FULL);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      valid     <= 1'b0;
      out       <= '0;
      burst_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (issue) begin
            valid <= 1'b1;
            state <= ISSUED;
            if (grant_ref) begin
              out <= r_mem[r_rd_ptr];
              // Only count reflection grants that made a primary ray wait.
              if (p_ne)
                burst_cnt <= (burst_cnt == BURST_MAX) ? BURST_MAX : burst_cnt + BW'(1);
              else
                burst_cnt <= '0;
            end else begin
              out       <= p_mem[p_rd_ptr];
              burst_cnt <= '0;
            end
          end else begin
            valid <= 1'b0;
          end
        end
        ISSUED: begin
          valid <= 1'b0;
          state <= IDLE;
        end
        default: begin
          valid <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_surface_ray_arbiter.sv
module tb_surface_ray_arbiter;
  import surface_ray_pkg::*;

  localparam int unsigned PD = 2;
  localparam int unsigned RD = 2;

  logic            clk;
  logic            resetn;
  logic            add_input;
  SurfaceInputData input_data;
  logic            add_ref_input;
  SurfaceInputData ref_input_data;
  logic            output_fifo_full;

  logic            full_d  [2];
  logic            rfull_d [2];
  logic            valid_d [2];
  SurfaceInputData out_d   [2];

  // Instance 0 uses default parameters, instance 1 a burst limit of 1.
  surface_ray_arbiter dut (
    .clk(clk), .resetn(resetn),
    .add_input(add_input), .input_data(input_data), .fifo_full(full_d[0]),
    .add_ref_input(add_ref_input), .ref_input_data(ref_input_data),
    .ref_fifo_full(rfull_d[0]), .output_fifo_full(output_fifo_full),
    .valid(valid_d[0]), .out(out_d[0])
  );

  surface_ray_arbiter #(.PRIM_DEPTH(2), .REF_DEPTH(2), .REF_BURST(1)) dut_b1 (
    .clk(clk), .resetn(resetn),
    .add_input(add_input), .input_data(input_data), .fifo_full(full_d[1]),
    .add_ref_input(add_ref_input), .ref_input_data(ref_input_data),
    .ref_fifo_full(rfull_d[1]), .output_fifo_full(output_fifo_full),
    .valid(valid_d[1]), .out(out_d[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference model: ray queues, a "busy" flag for the dead cycle after an
  // issue, and a count of reflection rays issued while a primary ray waited.
  SurfaceInputData pq [2][$];
  SurfaceInputData rq [2][$];
  int unsigned     waited_refs [2];
  int unsigned     burst_lim   [2];
  bit              busy        [2];
  bit              m_valid     [2];
  SurfaceInputData m_out       [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      pq[k].delete();
      rq[k].delete();
      waited_refs[k] = 0;
      busy[k]        = 0;
      m_valid[k]     = 0;
      m_out[k]       = '0;
    end
    burst_lim[0] = 4;
    burst_lim[1] = 1;
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      bit have_p, have_r, acc_p, acc_r, take_ref;
      have_p = pq[k].size() != 0;
      have_r = rq[k].size() != 0;
      acc_p  = add_input && (pq[k].size() < PD);
      acc_r  = add_ref_input && (rq[k].size() < RD);
      if (busy[k]) begin
        busy[k]    = 0;
        m_valid[k] = 0;
      end else if (!output_fifo_full && (have_p || have_r)) begin
        take_ref = have_r && !(have_p && waited_refs[k] >= burst_lim[k]);
        if (take_ref) begin
          m_out[k] = rq[k].pop_front();
          if (have_p) begin
            if (waited_refs[k] < burst_lim[k]) waited_refs[k]++;
          end else begin
            waited_refs[k] = 0;
          end
        end else begin
          m_out[k]       = pq[k].pop_front();
          waited_refs[k] = 0;
        end
        m_valid[k] = 1;
        busy[k]    = 1;
      end else begin
        m_valid[k] = 0;
      end
      if (acc_p) pq[k].push_back(input_data);
      if (acc_r) rq[k].push_back(ref_input_data);
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  function automatic SurfaceInputData mk(int unsigned id, int unsigned x, int unsigned y);
    SurfaceInputData d;
    d.x = x[15:0];
    d.y = y[15:0];
    d.ray_id = id[7:0];
    return d;
  endfunction

  task automatic idle_inputs();
    add_input        = 0;
    add_ref_input    = 0;
    input_data       = '0;
    ref_input_data   = '0;
    output_fifo_full = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    resetn = 0;
    model_reset();
    #3;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (valid_d[k] !== 1'b0 || out_d[k] !== '0 || full_d[k] !== 1'b0 || rfull_d[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset[%0d]: valid=%b out=%h full=%b rfull=%b, required 0/0/0/0",
                 k, valid_d[k], out_d[k], full_d[k], rfull_d[k]);
      end
    end
    @(negedge clk);
    resetn = 1;
  endtask

  task automatic test_single();
    add_input  = 1;
    input_data = mk(1, 5, 7);
    tick();
    add_input = 0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (valid_d[k] !== 1'b0 || full_d[k] !== 1'b0) begin
        errors++;
        $display("FAIL single_e1[%0d]: valid=%b full=%b, required 0/0", k, valid_d[k], full_d[k]);
      end
    end
    tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (valid_d[k] !== 1'b1 || out_d[k].x !== 16'd5 || out_d[k].y !== 16'd7 || full_d[k] !== 1'b0) begin
        errors++;
        $display("FAIL single_e2[%0d]: valid=%b x=%0d y=%0d full=%b, required 1/5/7/0",
                 k, valid_d[k], out_d[k].x, out_d[k].y, full_d[k]);
      end
    end
    tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (valid_d[k] !== 1'b0 || out_d[k].x !== 16'd5) begin
        errors++;
        $display("FAIL single_e3[%0d]: valid=%b x=%0d, required 0/5 (held)", k, valid_d[k], out_d[k].x);
      end
    end
  endtask

  task automatic test_fill_drop();
    int unsigned n_pulse, first_cyc, gap;
    logic [7:0] ids [2];
    logic exp_full [3];
    exp_full[0] = 0; exp_full[1] = 1; exp_full[2] = 1;
    output_fifo_full = 1;
    for (int i = 0; i < 3; i++) begin
      add_input  = 1;
      input_data = mk(10 + i, 100 + i, 200 + i);
      tick();
      checks++;
      if (full_d[0] !== exp_full[i] || valid_d[0] !== 1'b0) begin
        errors++;
        $display("FAIL fill_w%0d: full=%b valid=%b, required %b/0", i, full_d[0], valid_d[0], exp_full[i]);
      end
    end
    add_input = 0;
    output_fifo_full = 0;
    n_pulse = 0; first_cyc = 0; gap = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (valid_d[0] === 1'b1) begin
        if (n_pulse < 2) ids[n_pulse] = out_d[0].ray_id;
        if (n_pulse == 0) first_cyc = c;
        if (n_pulse == 1) gap = c - first_cyc;
        n_pulse++;
      end
    end
    checks++;
    if (n_pulse != 2 || gap != 2 || ids[0] !== 8'd10 || ids[1] !== 8'd11) begin
      errors++;
      $display("FAIL fill_drain: pulses=%0d gap=%0d ids=%0d,%0d, required 2/2/10,11",
               n_pulse, gap, ids[0], ids[1]);
    end
  endtask

  task automatic test_burst();
    int unsigned n [2];
    logic [7:0] got [2][4];
    logic [7:0] exp [2][4];
    exp[0] = '{8'd30, 8'd31, 8'd20, 8'd21};
    exp[1] = '{8'd30, 8'd20, 8'd31, 8'd21};
    output_fifo_full = 1;
    for (int i = 0; i < 2; i++) begin
      add_input      = 1;
      add_ref_input  = 1;
      input_data     = mk(20 + i, $urandom_range(0, 65535), $urandom_range(0, 65535));
      ref_input_data = mk(30 + i, $urandom_range(0, 65535), $urandom_range(0, 65535));
      tick();
    end
    add_input = 0;
    add_ref_input = 0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (full_d[k] !== 1'b1 || rfull_d[k] !== 1'b1) begin
        errors++;
        $display("FAIL burst_full[%0d]: full=%b rfull=%b, required 1/1", k, full_d[k], rfull_d[k]);
      end
    end
    output_fifo_full = 0;
    n[0] = 0; n[1] = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      for (int k = 0; k < 2; k++)
        if (valid_d[k] === 1'b1) begin
          if (n[k] < 4) got[k][n[k]] = out_d[k].ray_id;
          n[k]++;
        end
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (n[k] != 4) begin
        errors++;
        $display("FAIL burst_count[%0d]: pulses=%0d, required 4", k, n[k]);
      end else begin
        for (int i = 0; i < 4; i++) begin
          checks++;
          if (got[k][i] !== exp[k][i]) begin
            errors++;
            $display("FAIL burst_order[%0d][%0d]: id=%0d, required %0d", k, i, got[k][i], exp[k][i]);
          end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit seen;
    int unsigned late;
    output_fifo_full = 1;
    for (int i = 0; i < 2; i++) begin
      add_input  = 1;
      input_data = mk(40 + i, 7 * i, 9 * i);
      tick();
    end
    add_input = 0;
    output_fifo_full = 0;
    seen = 0;
    for (int c = 0; c < 6 && !seen; c++) begin
      tick();
      if (valid_d[0] === 1'b1) seen = 1;
    end
    checks++;
    if (!seen || out_d[0].ray_id !== 8'd40) begin
      errors++;
      $display("FAIL bp_first: seen=%0d id=%0d, required 1/40", seen, out_d[0].ray_id);
    end
    output_fifo_full = 1;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (valid_d[0] !== 1'b0 || valid_d[0] !== m_valid[0]) begin
        errors++;
        $display("FAIL bp_hold c%0d: valid=%b, required 0", c, valid_d[0]);
      end
    end
    output_fifo_full = 0;
    seen = 0; late = 0;
    for (int c = 0; c < 6 && !seen; c++) begin
      tick();
      late = c;
      if (valid_d[0] === 1'b1) seen = 1;
    end
    checks++;
    if (!seen || late != 0 || out_d[0].ray_id !== 8'd41) begin
      errors++;
      $display("FAIL bp_resume: seen=%0d cycle=%0d id=%0d, required 1/0/41", seen, late, out_d[0].ray_id);
    end
    tick();
  endtask

  task automatic test_reset_midflight();
    output_fifo_full = 1;
    for (int i = 0; i < 2; i++) begin
      add_input      = 1;
      add_ref_input  = 1;
      input_data     = mk(50 + i, 1, 2);
      ref_input_data = mk(60 + i, 3, 4);
      tick();
    end
    output_fifo_full = 0;
    tick();
    add_input = 0;
    add_ref_input = 0;
    checks++;
    if (valid_d[0] !== 1'b1 || full_d[0] !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre: valid=%b full=%b, required 1/1", valid_d[0], full_d[0]);
    end
    #2;
    resetn = 0;
    model_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (valid_d[k] !== 1'b0 || full_d[k] !== 1'b0 || rfull_d[k] !== 1'b0 || out_d[k] !== '0) begin
        errors++;
        $display("FAIL midrst[%0d]: valid=%b full=%b rfull=%b out=%h, required 0/0/0/0",
                 k, valid_d[k], full_d[k], rfull_d[k], out_d[k]);
      end
    end
    @(negedge clk);
    resetn = 1;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if (valid_d[0] !== 1'b0 || valid_d[1] !== 1'b0) begin
        errors++;
        $display("FAIL midrst_quiet c%0d: valid=%b/%b, required 0/0", c, valid_d[0], valid_d[1]);
      end
    end
    add_ref_input  = 1;
    ref_input_data = mk(77, 11, 12);
    tick();
    add_ref_input = 0;
    tick();
    checks++;
    if (valid_d[0] !== 1'b1 || out_d[0].ray_id !== 8'd77) begin
      errors++;
      $display("FAIL midrst_after: valid=%b id=%0d, required 1/77", valid_d[0], out_d[0].ray_id);
    end
    tick();
  endtask

  task automatic test_random();
    int unsigned bad = 0;
    for (int c = 0; c < 400; c++) begin
      add_input        = ($urandom_range(0, 2) == 0);
      add_ref_input    = ($urandom_range(0, 2) == 0);
      output_fifo_full = ($urandom_range(0, 3) == 0);
      input_data       = mk($urandom_range(0, 255), $urandom_range(0, 65535), $urandom_range(0, 65535));
      ref_input_data   = mk($urandom_range(0, 255), $urandom_range(0, 65535), $urandom_range(0, 65535));
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (valid_d[k] !== m_valid[k] || out_d[k] !== m_out[k] ||
            full_d[k] !== (pq[k].size() == PD) || rfull_d[k] !== (rq[k].size() == RD)) begin
          errors++;
          if (bad < 10)
            $display("FAIL random[%0d] c%0d: valid=%b out=%h full=%b rfull=%b, required %b/%h/%b/%b",
                     k, c, valid_d[k], out_d[k], full_d[k], rfull_d[k], m_valid[k], m_out[k],
                     pq[k].size() == PD, rq[k].size() == RD);
          bad++;
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_drop();
    test_burst();
    test_backpressure();
    test_reset_midflight();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
